// File: rtl/comparator_4bit_pkg.sv
// Shared types and constants for the 4-bit magnitude comparator and its combinational core.
package comparator_4bit_pkg;

  typedef struct packed {
    logic gt;
    logic eq;
    logic lt;
  } cmp_result_t;

  // "Equal, nothing decided yet": the register reset value and the cascade tie-off for a chain head.
  localparam cmp_result_t CMP_EQ_IDLE = '{gt: 1'b0, eq: 1'b1, lt: 1'b0};

endpackage

// File: rtl/comparator_4bit_cmp.sv
// Combinational magnitude compare with cascade pass-through on equal operands.
module cmp_core
  import comparator_4bit_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  input  cmp_result_t      cascade_in,
  output cmp_result_t      result
);

  logic [WIDTH-1:0] sign_flip;
  logic [WIDTH-1:0] a_key;
  logic [WIDTH-1:0] b_key;

  // Flipping the sign bit maps two's complement order onto unsigned order.
  assign sign_flip = {signed_mode, {(WIDTH-1){1'b0}}};
  assign a_key     = a ^ sign_flip;
  assign b_key     = b ^ sign_flip;

  always_comb begin
    result = cascade_in;
    if (a_key > b_key) begin
      result = '{gt: 1'b1, eq: 1'b0, lt: 1'b0};
    end else if (a_key < b_key) begin
      result = '{gt: 1'b0, eq: 1'b0, lt: 1'b1};
    end
  end

endmodule

// File: rtl/comparator_4bit.sv
// 4-bit magnitude comparator: combinational flags plus a valid-qualified one-cycle registered copy.
module comparator_4bit
  import comparator_4bit_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             signed_mode,
  input  logic             cas_gt_in,
  input  logic             cas_eq_in,
  input  logic             cas_lt_in,
  input  logic             in_valid,
  output logic             A_gt_B,
  output logic             A_eq_B,
  output logic             A_lt_B,
  output logic             gt_q,
  output logic             eq_q,
  output logic             lt_q,
  output logic             out_valid
);

  cmp_result_t cascade_in;
  cmp_result_t flags;
  cmp_result_t flags_d;
  cmp_result_t flags_q;
  logic        out_valid_d;
  logic        out_valid_q;

  assign cascade_in = '{gt: cas_gt_in, eq: cas_eq_in, lt: cas_lt_in};

  cmp_core #(
    .WIDTH(WIDTH)
  ) u_cmp_core (
    .a           (A),
    .b           (B),
    .signed_mode (signed_mode),
    .cascade_in  (cascade_in),
    .result      (flags)
  );

  assign A_gt_B = flags.gt;
  assign A_eq_B = flags.eq;
  assign A_lt_B = flags.lt;

  always_comb begin
    flags_d     = flags_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      flags_d = flags;
    end
  end

  // Capture stage: flags hold between accepted samples, valid is a one-cycle pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q     <= CMP_EQ_IDLE;
      out_valid_q <= 1'b0;
    end else begin
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign gt_q      = flags_q.gt;
  assign eq_q      = flags_q.eq;
  assign lt_q      = flags_q.lt;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_comparator_4bit.sv
// Directed and randomized bench for comparator_4bit against an integer-valued reference model.
module tb_comparator_4bit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] A = 4'd0;
  logic [3:0] B = 4'd0;
  logic       signed_mode = 1'b0;
  logic       cas_gt_in = 1'b0;
  logic       cas_eq_in = 1'b1;
  logic       cas_lt_in = 1'b0;
  logic       in_valid = 1'b0;
  logic       A_gt_B, A_eq_B, A_lt_B;
  logic       gt_q, eq_q, lt_q;
  logic       out_valid;

  int pass_cnt = 0;
  int total_cnt = 0;

  comparator_4bit #(.WIDTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .A           (A),
    .B           (B),
    .signed_mode (signed_mode),
    .cas_gt_in   (cas_gt_in),
    .cas_eq_in   (cas_eq_in),
    .cas_lt_in   (cas_lt_in),
    .in_valid    (in_valid),
    .A_gt_B      (A_gt_B),
    .A_eq_B      (A_eq_B),
    .A_lt_B      (A_lt_B),
    .gt_q        (gt_q),
    .eq_q        (eq_q),
    .lt_q        (lt_q),
    .out_valid   (out_valid)
  );

  always #5 clk = ~clk;

  // Expected {gt,eq,lt} from the numeric values of the operands.
  function automatic logic [2:0] model(input logic [3:0] a, input logic [3:0] b,
                                       input logic sm, input logic [2:0] cas);
    int av;
    int bv;
    av = int'(a);
    bv = int'(b);
    if (sm && av >= 8) av = av - 16;
    if (sm && bv >= 8) bv = bv - 16;
    if (av > bv) return 3'b100;
    if (av < bv) return 3'b001;
    return cas;
  endfunction

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  function automatic logic [2:0] comb_flags();
    return {A_gt_B, A_eq_B, A_lt_B};
  endfunction

  function automatic logic [2:0] reg_flags();
    return {gt_q, eq_q, lt_q};
  endfunction

  task automatic set_ops(input logic [3:0] a, input logic [3:0] b, input logic sm,
                         input logic [2:0] cas);
    A = a;
    B = b;
    signed_mode = sm;
    {cas_gt_in, cas_eq_in, cas_lt_in} = cas;
  endtask

  initial begin
    logic [2:0] exp_flags;
    logic       exp_vld;

    // Reset state
    #1 rst = 1'b1;
    #1;
    check("reset_flags", reg_flags(), 3'b010);
    check("reset_valid", {2'b0, out_valid}, 3'b000);
    @(negedge clk);
    rst = 1'b0;

    // Unsigned directed sweep
    set_ops(4'b0000, 4'b0000, 1'b0, 3'b010); #10 check("u_0_0", comb_flags(), 3'b010);
    set_ops(4'b0001, 4'b0011, 1'b0, 3'b010); #10 check("u_1_3", comb_flags(), 3'b001);
    set_ops(4'b0010, 4'b0001, 1'b0, 3'b010); #10 check("u_2_1", comb_flags(), 3'b100);
    set_ops(4'b0011, 4'b0011, 1'b0, 3'b010); #10 check("u_3_3", comb_flags(), 3'b010);

    // Signed vs unsigned interpretation of the same bits
    set_ops(4'b1111, 4'b0001, 1'b1, 3'b010); #10 check("s_m1_1", comb_flags(), 3'b001);
    set_ops(4'b1111, 4'b0001, 1'b0, 3'b010); #10 check("u_15_1", comb_flags(), 3'b100);
    set_ops(4'b1000, 4'b0111, 1'b1, 3'b010); #10 check("s_m8_7", comb_flags(), 3'b001);

    // Cascade pass-through and local dominance
    set_ops(4'b0101, 4'b0101, 1'b0, 3'b100); #10 check("cas_gt", comb_flags(), 3'b100);
    set_ops(4'b0101, 4'b0101, 1'b0, 3'b001); #10 check("cas_lt", comb_flags(), 3'b001);
    set_ops(4'b0110, 4'b0101, 1'b0, 3'b001); #10 check("cas_dom", comb_flags(), 3'b100);
    set_ops(4'b0101, 4'b0101, 1'b0, 3'b101); #10 check("cas_bad", comb_flags(), 3'b101);

    // Exhaustive both modes with default tie-off
    for (int m = 0; m < 2; m++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          set_ops(4'(a), 4'(b), 1'(m), 3'b010);
          #1;
          check("exh", comb_flags(), model(4'(a), 4'(b), 1'(m), 3'b010));
          check("exh_onehot", {2'b0, ($countones(comb_flags()) == 1)}, 3'b001);
        end
      end
    end

    // Registered path: capture then hold
    @(negedge clk);
    set_ops(4'b1000, 4'b0111, 1'b0, 3'b010);
    in_valid = 1'b1;
    @(posedge clk); #1;
    check("reg_cap_flags", reg_flags(), 3'b100);
    check("reg_cap_valid", {2'b0, out_valid}, 3'b001);
    in_valid = 1'b0;
    set_ops(4'b0001, 4'b0101, 1'b0, 3'b010);
    @(posedge clk); #1;
    check("reg_hold_flags", reg_flags(), 3'b100);
    check("reg_hold_valid", {2'b0, out_valid}, 3'b000);

    // Randomized registered and combinational traffic
    for (int i = 0; i < 300; i++) begin
      set_ops(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
              3'($urandom_range(0, 7)));
      in_valid = 1'($urandom_range(0, 1));
      #1;
      exp_flags = model(A, B, signed_mode, {cas_gt_in, cas_eq_in, cas_lt_in});
      check("rnd_comb", comb_flags(), exp_flags);
      if (!in_valid) exp_flags = reg_flags();
      exp_vld = in_valid;
      @(posedge clk); #1;
      check("rnd_reg_flags", reg_flags(), exp_flags);
      check("rnd_reg_valid", {2'b0, out_valid}, {2'b0, exp_vld});
    end

    // Asynchronous reset mid-cycle with a pending valid
    set_ops(4'b0011, 4'b0001, 1'b0, 3'b010);
    in_valid = 1'b1;
    @(posedge clk); #1;
    check("pre_rst_valid", {2'b0, out_valid}, 3'b001);
    #2 rst = 1'b1;
    #1;
    check("async_rst_flags", reg_flags(), 3'b010);
    check("async_rst_valid", {2'b0, out_valid}, 3'b000);
    set_ops(4'b0010, 4'b1001, 1'b0, 3'b010);
    #1 check("rst_comb_track", comb_flags(), 3'b001);
    @(posedge clk); #1;
    check("rst_held_valid", {2'b0, out_valid}, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_cap", reg_flags(), 3'b001);
    check("post_rst_valid", {2'b0, out_valid}, 3'b001);
    in_valid = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
